// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: start/busy/done handshake and operand/product bus of the multiplier
//   start        issuer -> sequencer  request, honoured only while busy=0
//   multiplicand issuer -> sequencer  operand M, captured on an accepted start
//   multiplier   issuer -> sequencer  operand Q, captured on an accepted start
//   busy         sequencer -> issuer  multiply in flight
//   done         sequencer -> issuer  one-cycle completion pulse
//   product      sequencer -> issuer  registered 64-bit result
interface alu_mul_sequencer_if;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    modport master (output start, multiplicand, multiplier, input busy, done, product);
    modport slave (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 32x32->64 unsigned shift-and-add multiplier driving one shared 32-bit ALU
//   alu32:             i_command, i_a, i_b -> o_result, o_carryout (combinational)
//   alu_mul_sequencer: clk, reset (sync, active-high), bus (slave side of alu_mul_sequencer_if)
module alu32 (
    input  logic [2:0]  i_command,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_carryout
);
    logic [32:0] w_add;
    logic [32:0] w_sub;
    assign w_add = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
    always_comb begin
        o_result   = 32'd0;
        o_carryout = 1'b0;
        case (i_command)
            3'd0:    {o_carryout, o_result} = w_add;
            3'd1:    {o_carryout, o_result} = w_sub;
            3'd2:    o_result = i_a & i_b;
            3'd3:    o_result = i_a | i_b;
            3'd4:    o_result = i_a ^ i_b;
            default: o_result = 32'd0;
        endcase
    end
endmodule

module alu_mul_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    alu_mul_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [2:0] ALU_ADD = 3'd0;
    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_p;
    logic [31:0] r_m;
    logic [4:0]  r_cnt;
    logic [63:0] r_product;
    logic [31:0] w_sum;
    logic        w_carry;
    logic [63:0] w_step;
    logic        w_last;
    alu32 u_alu (
        .i_command  (ALU_ADD),
        .i_a        (r_p[63:32]),
        .i_b        (r_p[0] ? r_m : 32'd0),
        .o_result   (w_sum),
        .o_carryout (w_carry)
    );
    // add, then shift right one with the ALU carry landing in P[63]
    assign w_step = {w_carry, w_sum, r_p[31:1]};
    assign w_last = (r_cnt == 5'd31);
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p       <= 64'd0;
            r_m       <= 32'd0;
            r_cnt     <= 5'd0;
            r_product <= 64'd0;
        end else if (r_state == IDLE && bus.start) begin
            r_p   <= {32'd0, bus.multiplier};
            r_m   <= bus.multiplicand;
            r_cnt <= 5'd0;
        end else if (r_state == RUN) begin
            r_p   <= w_step;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) r_product <= w_step;
        end
    end
    // decoded from the state register only, so no path from start
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.product = r_product;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed checks of latency, products, handshake and reset behaviour
module tb_alu_mul_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   nd;
    int   last;
    alu_mul_sequencer_if bus ();
    alu_mul_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #2000 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_mul(input string tag, input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp);
        int n;
        bus.start = 1'b1;
        bus.multiplicand = m;
        bus.multiplier = q;
        step();
        bus.start = 1'b0;
        check({tag, " busy rise"}, 64'(bus.busy), 64'd1);
        check({tag, " no early done"}, 64'(bus.done), 64'd0);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd32);
        check({tag, " product"}, bus.product, exp);
        step();
        check({tag, " done pulse width"}, 64'(bus.done), 64'd0);
        check({tag, " busy fall"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = 32'd0;
        bus.multiplier = 32'd0;
        @(negedge clk);
        step();
        step();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset product", bus.product, 64'd0);
        reset = 1'b0;
        step();

        run_mul("3x5", 32'd3, 32'd5, 64'd15);
        run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_mul("zero", 32'd0, 32'h1234_5678, 64'd0);
        run_mul("msb x 2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
        run_mul("identity", 32'hDEAD_BEEF, 32'd1, 64'h0000_0000_DEAD_BEEF);

        bus.start = 1'b1;
        bus.multiplicand = 32'd7;
        bus.multiplier = 32'd9;
        step();
        nd = 0;
        for (int i = 1; i <= 40; i++) begin
            bus.start = (i == 5 || i == 20 || i == 33);
            bus.multiplicand = 32'd100;
            bus.multiplier = 32'd100;
            step();
            if (bus.done === 1'b1) nd++;
        end
        bus.start = 1'b0;
        check("busy-start done count", 64'(nd), 64'd1);
        check("busy-start product", bus.product, 64'd63);
        check("busy-start idle", 64'(bus.busy), 64'd0);
        step();
        check("busy-start product held", bus.product, 64'd63);

        bus.start = 1'b1;
        bus.multiplicand = 32'd1234;
        bus.multiplier = 32'd5678;
        step();
        bus.start = 1'b0;
        repeat (14) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid-reset busy", 64'(bus.busy), 64'd0);
        check("mid-reset product", bus.product, 64'd0);
        check("mid-reset done", 64'(bus.done), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done === 1'b1) nd++;
        end
        check("mid-reset no done", 64'(nd), 64'd0);
        run_mul("6x7", 32'd6, 32'd7, 64'd42);

        bus.start = 1'b1;
        bus.multiplicand = 32'h0001_0000;
        bus.multiplier = 32'h0001_0000;
        nd = 0;
        last = -1;
        for (int i = 1; i <= 110; i++) begin
            step();
            if (bus.done === 1'b1) begin
                nd++;
                check("b2b product", bus.product, 64'h0000_0001_0000_0000);
                if (last >= 0) check("b2b interval", 64'(i - last), 64'd34);
                last = i;
            end
        end
        bus.start = 1'b0;
        check("b2b done count", 64'(nd), 64'd3);
        repeat (40) step();
        check("b2b drained", 64'(bus.busy), 64'd0);

        reset = 1'b1;
        bus.start = 1'b1;
        bus.multiplicand = 32'd9;
        bus.multiplier = 32'd9;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        check("reset+start busy", 64'(bus.busy), 64'd0);
        check("reset+start product", bus.product, 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.busy === 1'b1 || bus.done === 1'b1) nd++;
        end
        check("reset+start stays idle", 64'(nd), 64'd0);
        check("reset+start product held", bus.product, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
